uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one APB-attached UART transmitter among NUM_REQ byte-level clients. Arbitrates pending requests, drives the APB write (setup/access) into the transmitter, then holds the bus idle until the transmitter reports frame completion. Sits between client logic (GPIO/command blocks) and the uart_transmitter APB slave port.

---
 rtl/uart_apb_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_if.sv | 26 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART APB transmit path: FSM encoding, register map, byte-lane strobe.
// Pure declarations; no latency or backpressure of its own.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETUP     = 2'd1,
    ST_ACCESS    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_t;

  typedef logic [31:0] apb_addr_t;
  typedef logic [31:0] apb_data_t;

  localparam apb_addr_t UART_REG_TX_DATA = 32'h0000_0079;
  localparam apb_addr_t TX_ADDR_DEFAULT  = UART_REG_TX_DATA;
  localparam logic [3:0] PSTRB_BYTE0     = 4'b0001;

  function automatic apb_data_t tx_wdata(input logic [7:0] tx_byte);
    return {24'h0, tx_byte};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// APB master/slave bundle between the scheduler and the UART transmitter, plus its frame-complete pulse.
// Wires only; APB pready provides the backpressure.
interface uart_tx_scheduler_if;
  import uart_apb_pkg::*;

  logic      psel;
  logic      penable;
  logic      pwrite;
  apb_addr_t paddr;
  apb_data_t pwdata;
  logic [3:0] pstrb;
  logic      pready;
  logic      pslverr;
  logic      tx_done;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr, tx_done
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr, tx_done
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; combinational, zero latency.
// No backpressure; vld is low when no request is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always below NUM_REQ, so one subtraction is enough to wrap
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!vld && req[cand[IDX_W-1:0]]) begin
        vld                      = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one APB UART transmitter among NUM_REQ clients: round-robin grant, APB write, wait for tx_done.
// gnt/psel one cycle after req; clients hold req until gnt, pready stretches ACCESS, tx_done/timeout ends the frame.
module uart_tx_scheduler
  import uart_apb_pkg::*;
#(
  parameter int        NUM_REQ        = 2,
  parameter apb_addr_t TX_ADDR        = TX_ADDR_DEFAULT,
  parameter int        TIMEOUT_CYCLES = 4096
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic                   busy,
  uart_tx_scheduler_if.master    apb
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_t       state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [7:0]         data_q;
  logic [CNT_W-1:0]   cnt;
  logic               tx_done_seen;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] done_nxt;
  logic               err_nxt;
  logic               apb_on_nxt;
  logic [7:0]         byte_nxt;

  logic [7:0] req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    done_nxt  = '0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt = ST_SETUP;
          gnt_nxt   = arb_gnt;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          if (apb.pslverr) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (apb.tx_done || tx_done_seen) begin
          done_nxt[owner] = 1'b1;
          state_nxt       = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign apb_on_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
  // On the grant edge the byte comes straight from the winning client; afterwards from the latch
  assign byte_nxt   = (state == ST_IDLE) ? req_bytes[arb_idx] : data_q;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      ptr          <= '0;
      owner        <= '0;
      data_q       <= '0;
      cnt          <= '0;
      tx_done_seen <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      apb.psel     <= 1'b0;
      apb.penable  <= 1'b0;
      apb.pwrite   <= 1'b0;
      apb.paddr    <= '0;
      apb.pwdata   <= '0;
      apb.pstrb    <= '0;
    end else begin
      if (state == ST_IDLE && arb_vld) begin
        owner  <= arb_idx;
        data_q <= req_bytes[arb_idx];
        ptr    <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
      end

      // A frame can finish while the APB write is still being acknowledged
      if (state == ST_IDLE) begin
        tx_done_seen <= 1'b0;
      end else if (state == ST_ACCESS && apb.tx_done) begin
        tx_done_seen <= 1'b1;
      end

      if (state == ST_WAIT_DONE) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      gnt         <= gnt_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      busy        <= (state_nxt != ST_IDLE);
      apb.psel    <= apb_on_nxt;
      apb.penable <= (state_nxt == ST_ACCESS);
      apb.pwrite  <= apb_on_nxt;
      apb.paddr   <= apb_on_nxt ? TX_ADDR : '0;
      apb.pwdata  <= apb_on_nxt ? tx_wdata(byte_nxt) : '0;
      apb.pstrb   <= apb_on_nxt ? PSTRB_BYTE0 : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scenario bench for uart_tx_scheduler with a round-robin reference model and randomized transfers.
module tb_uart_tx_scheduler;

  localparam int N = 3;
  localparam int T = 32;

  logic           pclk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic           busy;

  uart_tx_scheduler_if bus();

  uart_tx_scheduler #(
    .NUM_REQ        (N),
    .TX_ADDR        (32'h0000_0079),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .apb      (bus.master)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;
  int mptr     = 0;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Drives one full transfer from IDLE. mode 0: tx_done after delay cycles in WAIT_DONE,
  // mode 1: tx_done during first ACCESS cycle, mode 2: no tx_done (timeout).
  task automatic do_transfer(input logic [N-1:0] reqv, input logic [N*8-1:0] bytes,
                             input int ws, input bit slverr, input int mode, input int delay);
    int         w;
    logic [7:0] b;
    logic [N-1:0] oh;
    w  = rr_pick(reqv, mptr);
    b  = bytes[w*8 +: 8];
    oh = '0;
    oh[w] = 1'b1;
    req = reqv; req_data = bytes;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.tx_done = 1'($urandom);
    step();
    checks++;
    if (gnt !== oh || bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.pwrite !== 1'b1 ||
        bus.paddr !== 32'h79 || bus.pwdata !== {24'h0, b} || bus.pstrb !== 4'b0001 || busy !== 1'b1)
      begin
      failures++;
      $display("FAIL setup: gnt=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b busy=%b; want gnt=%b psel=1 penable=0 pwrite=1 paddr=00000079 pwdata=%h pstrb=0001 busy=1",
               gnt, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, busy, oh, {24'h0, b});
    end
    mptr = (w + 1) % N;
    req = N'($urandom);
    bus.tx_done = 1'($urandom);
    step();
    for (int i = 0; i <= ws; i++) begin
      checks++;
      if (gnt !== '0 || bus.psel !== 1'b1 || bus.penable !== 1'b1 || bus.pwrite !== 1'b1 ||
          bus.paddr !== 32'h79 || bus.pwdata !== {24'h0, b} || bus.pstrb !== 4'b0001 || err !== 1'b0) begin
        failures++;
        $display("FAIL access[%0d]: gnt=%b psel=%b penable=%b pwdata=%h pstrb=%b err=%b; want gnt=0 psel=1 penable=1 pwdata=%h pstrb=0001 err=0",
                 i, gnt, bus.psel, bus.penable, bus.pwdata, bus.pstrb, err, {24'h0, b});
      end
      bus.pready  = (i == ws);
      bus.pslverr = slverr && (i == ws);
      bus.tx_done = (mode == 1) && (i == 0);
      req = N'($urandom);
      step();
      bus.pready = 1'b0; bus.pslverr = 1'b0; bus.tx_done = 1'b0;
    end
    if (slverr) begin
      checks++;
      if (err !== 1'b1 || done !== '0 || busy !== 1'b0 || bus.psel !== 1'b0) begin
        failures++;
        $display("FAIL slverr: err=%b done=%b busy=%b psel=%b; want err=1 done=0 busy=0 psel=0", err, done, busy, bus.psel);
      end
    end else begin
      checks++;
      if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0 || bus.pstrb !== 4'b0 ||
          busy !== 1'b1 || err !== 1'b0 || done !== '0) begin
        failures++;
        $display("FAIL wait_entry: psel=%b penable=%b pwrite=%b pstrb=%b busy=%b err=%b done=%b; want 0 0 0 0000 busy=1 err=0 done=0",
                 bus.psel, bus.penable, bus.pwrite, bus.pstrb, busy, err, done);
      end
      if (mode == 2) begin
        for (int k = 1; k <= T; k++) begin
          req = N'($urandom);
          step();
          checks++;
          if ((k < T  && (err !== 1'b0 || busy !== 1'b1 || done !== '0)) ||
              (k == T && (err !== 1'b1 || busy !== 1'b0 || done !== '0))) begin
            failures++;
            $display("FAIL timeout[+%0d]: err=%b busy=%b done=%b; want err=%0d busy=%0d done=0",
                     k, err, busy, done, (k == T), (k < T));
          end
        end
      end else begin
        if (mode == 0) begin
          for (int k = 0; k < delay; k++) begin
            req = N'($urandom);
            step();
            checks++;
            if (done !== '0 || err !== 1'b0 || busy !== 1'b1) begin
              failures++;
              $display("FAIL wait[%0d]: done=%b err=%b busy=%b; want done=0 err=0 busy=1", k, done, err, busy);
            end
          end
          bus.tx_done = 1'b1;
        end
        req = N'($urandom);
        step();
        bus.tx_done = 1'b0;
        checks++;
        if (done !== oh || err !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
          failures++;
          $display("FAIL done: done=%b err=%b busy=%b gnt=%b; want done=%b err=0 busy=0 gnt=0", done, err, busy, gnt, oh);
        end
      end
    end
    req = '0;
    bus.tx_done = 1'($urandom);
    step();
    bus.tx_done = 1'b0;
    checks++;
    if (done !== '0 || err !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pulse_end: done=%b err=%b gnt=%b busy=%b; want all 0", done, err, gnt, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; req_data = '0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.tx_done = 1'b0;
    step(); step();
    checks++;
    if ({gnt, done, err, busy, bus.psel, bus.penable, bus.pwrite} !== '0 ||
        bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.pstrb !== 4'h0) begin
      failures++;
      $display("FAIL reset: gnt=%b done=%b err=%b busy=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b; want all 0",
               gnt, done, err, busy, bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb);
    end
    rst = 1'b1;
    mptr = 0;
    step();
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b; want 0 0", busy, gnt);
    end
  endtask

  task automatic test_single();
    do_transfer(3'b001, {8'h11, 8'h22, 8'h78}, 0, 1'b0, 0, 20);
  endtask

  task automatic test_contention();
    for (int n = 0; n < 4; n++) begin
      do_transfer(3'b011, {8'h00, 8'h3C, 8'hA5}, 0, 1'b0, 0, 2);
    end
  endtask

  task automatic test_wait_states();
    do_transfer(3'b100, {8'h5A, 8'h01, 8'h02}, 3, 1'b0, 0, 1);
  endtask

  task automatic test_slave_error();
    do_transfer(3'b010, {8'h00, 8'hE7, 8'h00}, 1, 1'b1, 0, 0);
    do_transfer(3'b010, {8'h00, 8'h42, 8'h00}, 0, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    do_transfer(3'b001, {8'h00, 8'h00, 8'hC3}, 0, 1'b0, 2, 0);
  endtask

  task automatic test_sticky();
    do_transfer(3'b110, {8'h9D, 8'h6B, 8'h00}, 2, 1'b0, 1, 0);
  endtask

  task automatic test_reset_mid();
    req = 3'b001; req_data = {8'h00, 8'h00, 8'hF0};
    step();
    checks++;
    if (gnt !== 3'b001 || bus.psel !== 1'b1) begin
      failures++;
      $display("FAIL mid_grant: gnt=%b psel=%b; want 001 1", gnt, bus.psel);
    end
    req = '0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({gnt, done, err, busy, bus.psel, bus.penable, bus.pwrite} !== '0 ||
        bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.pstrb !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset: gnt=%b done=%b err=%b busy=%b psel=%b penable=%b pwdata=%h; want all 0",
               gnt, done, err, busy, bus.psel, bus.penable, bus.pwdata);
    end
    rst = 1'b1;
    mptr = 0;
    for (int k = 0; k < 3; k++) begin
      bus.tx_done = (k == 0);
      step();
      bus.tx_done = 1'b0;
      checks++;
      if (done !== '0 || err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_quiet[%0d]: done=%b err=%b busy=%b; want 0 0 0", k, done, err, busy);
      end
    end
    do_transfer(3'b111, {8'h33, 8'h22, 8'h11}, 0, 1'b0, 0, 3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [N-1:0]   rv;
      logic [N*8-1:0] bv;
      int             r;
      rv = N'($urandom_range(1, (1 << N) - 1));
      bv = (N*8)'($urandom);
      r  = $urandom_range(0, 7);
      do_transfer(rv, bv, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                  (r < 6) ? 0 : (r == 6 ? 1 : 2), $urandom_range(0, 8));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
